spike_detection_avalon: RTL and testbench

//  Avalon-MM slave that monitors a 16-bit signed sample stream, flags spikes that deviate

---
 rtl/spike_detection_avalon.sv | 155 +++++++++++++++
 tb/tb_spike_detection_avalon.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_detection_avalon.sv
// Avalon-MM spike detector: 64-sample moving average, 150-sample capture window, level IRQ.
// Reads return data one cycle after acceptance; waitrequest is tied low, samples are never stalled.
module spike_detection_avalon #(
    parameter int ERRNO = 0
) (
    input  logic        avl_clk_i,
    input  logic        avl_reset_i,
    input  logic [13:0] avl_address_i,
    input  logic [3:0]  avl_byteenable_i,
    input  logic        avl_write_i,
    input  logic [15:0] avl_writedata_i,
    input  logic        avl_read_i,
    output logic        avl_readdatavalid_o,
    output logic [15:0] avl_readdata_o,
    output logic        avl_waitrequest_o,
    output logic        avl_irq_o,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i
);
    localparam int PRE  = (ERRNO == 2) ? 51 : 50;
    localparam int WLEN = 150;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READY} state_t;

    state_t             state_q, state_d;
    logic               active_q;
    logic [15:0]        thr_q;
    logic [15:0]        hist_q [64];
    logic [5:0]         wp_q;
    logic [6:0]         cnt_q;
    logic signed [21:0] sum_q, sum_d;
    logic [15:0]        win_q [WLEN];
    logic [7:0]         widx_q;
    logic               irq_q;
    logic [15:0]        rdata_q, rdata_d;
    logic               rdv_q;

    logic               wr_ctrl, start, stop, ack, ack_eff, acc, hist_full, trig, over;
    logic signed [15:0] mean;
    logic signed [16:0] diff;
    logic [16:0]        absd;

    logic unused_ok;
    assign unused_ok = ^avl_byteenable_i;

    assign wr_ctrl   = avl_write_i && (avl_address_i == 14'h0001);
    assign start     = wr_ctrl && avl_writedata_i[0] && !active_q;
    assign stop      = wr_ctrl && !avl_writedata_i[0];
    assign ack       = avl_write_i && (avl_address_i == 14'h0003);
    assign ack_eff   = ack && (state_q == S_READY) && (ERRNO != 1);
    assign acc       = sample_valid_i && active_q && !stop;
    assign hist_full = cnt_q[6];

    // Mean is taken from the history before the current sample enters it.
    assign mean = sum_q[21:6];
    assign diff = {sample_i[15], sample_i} - {mean[15], mean};
    assign absd = diff[16] ? 17'(-diff) : 17'(diff);
    assign over = (ERRNO == 3) ? (absd >= {1'b0, thr_q}) : (absd > {1'b0, thr_q});

    // An acknowledge in the same cycle as a sample frees the buffer first.
    assign trig = acc && hist_full && over &&
                  ((state_q == S_IDLE) || ack_eff);

    always_comb begin
        sum_d = sum_q + 22'(signed'(sample_i));
        if (hist_full)
            sum_d = sum_d - 22'(signed'(hist_q[wp_q]));
    end

    always_comb begin
        state_d = state_q;
        if (ack_eff)
            state_d = S_IDLE;
        if (trig)
            state_d = S_CAPTURE;
        else if (acc && (state_q == S_CAPTURE) && (widx_q == 8'(WLEN - 1)))
            state_d = S_READY;
        if (stop && (state_q == S_CAPTURE))
            state_d = S_IDLE;
    end

    always_comb begin
        rdata_d = 16'h0000;
        case (avl_address_i)
            14'h0000: rdata_d = 16'h5D01;
            14'h0001: rdata_d = {15'b0, active_q};
            14'h0002: rdata_d = {13'b0, hist_full, state_q == S_CAPTURE, state_q == S_READY};
            14'h0004: rdata_d = thr_q;
            default: begin
                if (avl_address_i[13:8] == 6'h10 && avl_address_i[7:0] < 8'(WLEN))
                    rdata_d = win_q[avl_address_i[7:0]];
            end
        endcase
    end

    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            state_q <= S_IDLE;
            active_q <= 1'b0;
            thr_q <= 16'd1000;
            wp_q <= 6'd0;
            cnt_q <= 7'd0;
            sum_q <= 22'sd0;
            widx_q <= 8'd0;
            irq_q <= 1'b0;
            rdata_q <= 16'h0000;
            rdv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q <= (state_d == S_READY);
            rdv_q <= avl_read_i;
            if (avl_read_i)
                rdata_q <= rdata_d;
            if (avl_write_i && avl_address_i == 14'h0004)
                thr_q <= avl_writedata_i;
            if (start) begin
                active_q <= 1'b1;
                wp_q <= 6'd0;
                cnt_q <= 7'd0;
                sum_q <= 22'sd0;
            end else if (stop) begin
                active_q <= 1'b0;
            end
            if (acc) begin
                wp_q <= wp_q + 6'd1;
                sum_q <= sum_d;
                if (!hist_full)
                    cnt_q <= cnt_q + 7'd1;
                if (trig)
                    widx_q <= 8'(PRE + 1);
                else if (state_q == S_CAPTURE)
                    widx_q <= widx_q + 8'd1;
            end
        end
    end

    // Sample storage needs no reset: history is qualified by cnt_q, window by state.
    always_ff @(posedge avl_clk_i) begin
        if (acc) begin
            hist_q[wp_q] <= sample_i;
            if (trig) begin
                for (int i = 0; i < PRE; i++)
                    win_q[i] <= hist_q[6'(wp_q - 6'(PRE - i))];
                win_q[PRE] <= sample_i;
            end else if (state_q == S_CAPTURE) begin
                win_q[widx_q] <= sample_i;
            end
        end
    end

    assign avl_readdatavalid_o = rdv_q;
    assign avl_readdata_o      = rdata_q;
    assign avl_waitrequest_o   = 1'b0;
    assign avl_irq_o           = irq_q;
endmodule

// File: tb/tb_spike_detection_avalon.sv
// Directed bench for spike_detection_avalon; register reads are checked by a queue-based monitor.
module tb_spike_detection_avalon;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] addr;
    logic [3:0]  be;
    logic        wr, rd, rdv, wreq, irq, svld;
    logic [15:0] wdat, rdat, smpl;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];
    string       name_q [$];
    logic        rd_prev = 1'b0;

    spike_detection_avalon dut (
        .avl_clk_i(clk), .avl_reset_i(rst_n), .avl_address_i(addr),
        .avl_byteenable_i(be), .avl_write_i(wr), .avl_writedata_i(wdat),
        .avl_read_i(rd), .avl_readdatavalid_o(rdv), .avl_readdata_o(rdat),
        .avl_waitrequest_o(wreq), .avl_irq_o(irq),
        .sample_i(smpl), .sample_valid_i(svld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: readdatavalid must follow a read by exactly one cycle; data popped from the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_prev || rdv)
                chk("rdv_timing", {15'b0, rdv}, {15'b0, rd_prev});
            if (rdv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rdv", 16'h0001, 16'h0000);
                end else begin
                    chk(name_q.pop_front(), rdat, exp_q.pop_front());
                end
            end
            rd_prev = rd;
        end else begin
            rd_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [13:0] a, input logic [15:0] d);
        addr = a; wdat = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rreg(input string name, input logic [13:0] a, input logic [15:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        addr = a; rd = 1'b1;
        chk("waitrequest", {15'b0, wreq}, 16'h0000);
        tick();
        rd = 1'b0;
    endtask

    task automatic smp(input logic [15:0] v);
        smpl = v; svld = 1'b1;
        tick();
        svld = 1'b0;
    endtask

    task automatic smp_n(input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) smp(v);
    endtask

    task automatic restart();
        wreg(14'h0001, 16'h0000);
        wreg(14'h0001, 16'h0001);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) chk("drain_timeout", 16'(exp_q.size()), 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; be = 4'hF; wr = 1'b0; rd = 1'b0;
        wdat = '0; svld = 1'b0; smpl = '0;
        repeat (3) tick();
        chk("reset_irq", {15'b0, irq}, 16'h0000);
        chk("reset_rdv", {15'b0, rdv}, 16'h0000);
        chk("reset_rdata", rdat, 16'h0000);
        rst_n = 1'b1;
        tick();
        rreg("reset_ctrl", 14'h0001, 16'h0000);
        rreg("reset_thr", 14'h0004, 16'd1000);
        rreg("reset_status", 14'h0002, 16'h0000);
        rreg("id", 14'h0000, 16'h5D01);

        // Steady input never trips the detector.
        wreg(14'h0001, 16'h0001);
        smp_n(64, 16'd100);
        smp_n(100, 16'd100);
        chk("flat_irq", {15'b0, irq}, 16'h0000);
        rreg("flat_status", 14'h0002, 16'h0004);

        // Basic spike with flat surroundings.
        restart();
        rreg("restart_status", 14'h0002, 16'h0000);
        smp_n(64, 16'd100);
        smp(16'd2000);
        rreg("cap_status", 14'h0002, 16'h0006);
        smp_n(98, 16'd100);
        chk("irq_before_last", {15'b0, irq}, 16'h0000);
        smp(16'd100);
        chk("irq_after_last", {15'b0, irq}, 16'h0001);
        rreg("ready_status", 14'h0002, 16'h0005);
        rreg("w0_flat", 14'h1000, 16'd100);
        rreg("w50_flat", 14'h1032, 16'd2000);
        rreg("w149_flat", 14'h1095, 16'd100);

        wreg(14'h0003, 16'h0000);
        chk("ack_irq", {15'b0, irq}, 16'h0000);
        rreg("ack_status", 14'h0002, 16'h0004);

        // Ramp around a negative spike pins down window ordering.
        for (int k = 0; k < 50; k++) smp(16'(100 + k));
        smp(16'hFA24);
        for (int j = 0; j < 99; j++) smp(16'(200 + j));
        chk("ramp_irq", {15'b0, irq}, 16'h0001);
        rreg("w0_ramp", 14'h1000, 16'd100);
        rreg("w49_ramp", 14'h1031, 16'd149);
        rreg("w50_ramp", 14'h1032, 16'hFA24);
        rreg("w51_ramp", 14'h1033, 16'd200);
        rreg("w149_ramp", 14'h1095, 16'd298);

        // Acknowledge and spike in the same cycle: ack first, then the sample triggers.
        addr = 14'h0003; wdat = '0; wr = 1'b1; smpl = 16'd3000; svld = 1'b1;
        tick();
        wr = 1'b0; svld = 1'b0;
        chk("ackspike_irq", {15'b0, irq}, 16'h0001 ^ 16'h0001);
        rreg("ackspike_status", 14'h0002, 16'h0006);
        smp_n(99, 16'd7);
        chk("ackspike_done_irq", {15'b0, irq}, 16'h0001);
        rreg("w0_ackspike", 14'h1000, 16'd249);
        rreg("w49_ackspike", 14'h1031, 16'd298);
        rreg("w50_ackspike", 14'h1032, 16'd3000);
        rreg("w149_ackspike", 14'h1095, 16'd7);
        wreg(14'h0003, 16'h0000);
        chk("ack2_irq", {15'b0, irq}, 16'h0000);

        // Threshold boundary: |1100-100| = 1000 is not a spike, 1001 is.
        restart();
        smp_n(64, 16'd100);
        smp(16'd1100);
        rreg("thr_equal", 14'h0002, 16'h0004);
        restart();
        smp_n(64, 16'd100);
        smp(16'd1101);
        rreg("thr_above", 14'h0002, 16'h0006);

        // Stop mid-capture aborts; samples while stopped are ignored.
        smp_n(10, 16'd100);
        wreg(14'h0001, 16'h0000);
        rreg("stop_ctrl", 14'h0001, 16'h0000);
        rreg("stop_status", 14'h0002, 16'h0004);
        smp_n(150, 16'd100);
        chk("stop_irq", {15'b0, irq}, 16'h0000);

        // Spike before history is full is ignored.
        wreg(14'h0001, 16'h0001);
        rreg("start_ctrl", 14'h0001, 16'h0001);
        smp_n(10, 16'd100);
        smp(16'd5000);
        rreg("early_spike", 14'h0002, 16'h0000);
        smp_n(53, 16'd100);
        rreg("early_full", 14'h0002, 16'h0004);
        wreg(14'h0001, 16'h0001);
        rreg("start_again_noop", 14'h0002, 16'h0004);

        // Register map odds and ends.
        wreg(14'h0004, 16'd500);
        rreg("thr_rw", 14'h0004, 16'd500);
        wreg(14'h0000, 16'h0000);
        rreg("id_ro", 14'h0000, 16'h5D01);
        rreg("unmapped", 14'h0005, 16'h0000);
        rreg("win_oob", 14'h10C8, 16'h0000);
        drain();

        // Asynchronous reset mid-capture.
        smp(16'd3000);
        smp_n(5, 16'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_irq", {15'b0, irq}, 16'h0000);
        chk("arst_rdv", {15'b0, rdv}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        rreg("arst_thr", 14'h0004, 16'd1000);
        rreg("arst_ctrl", 14'h0001, 16'h0000);
        rreg("arst_status", 14'h0002, 16'h0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
